// File: rtl/ps2_track_keys_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : ps2_track_keys_if
// Description : PS/2 pin pair plus decoded key/track outputs of the tracker.
//               master = keyboard pins / judgement logic side,
//               slave  = the ps2_track_keys receiver.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
interface ps2_track_keys_if #(
  parameter int NUM_TRACKS = 6
);
  logic                  key_clk;
  logic                  key_data;
  logic [NUM_TRACKS-1:0] track_held;
  logic [NUM_TRACKS-1:0] track_press;
  logic [NUM_TRACKS-1:0] track_release;
  logic                  code_valid;
  logic [7:0]            code_byte;
  logic                  code_break;
  logic                  code_ext;
  logic                  frame_err;

  modport master (
    output key_clk, key_data,
    input  track_held, track_press, track_release,
    input  code_valid, code_byte, code_break, code_ext, frame_err
  );

  modport slave (
    input  key_clk, key_data,
    output track_held, track_press, track_release,
    output code_valid, code_byte, code_break, code_ext, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/ps2_track_keys.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : ps2_track_keys
// Description : PS/2 keyboard frame receiver with make/break/extended decode
//               and a per-track held bitmap with press/release pulses.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module ps2_track_keys #(
  parameter int                          NUM_TRACKS     = 6,
  parameter logic [8*NUM_TRACKS-1:0]     KEYMAP         = {8'h70, 8'h69, 8'h6B, 8'h75, 8'h4A, 8'h0D},
  parameter int                          TIMEOUT_CYCLES = 200000
) (
  input  wire logic            clk_in,
  input  wire logic            key_reset,
  ps2_track_keys_if.slave      bus
);

  localparam int                C_IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_IDLE_W-1:0] C_IDLE_LAST = C_IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]        C_BIT_STOP  = 4'd10;
  localparam logic [7:0]        C_CODE_EXT  = 8'hE0;
  localparam logic [7:0]        C_CODE_BRK  = 8'hF0;
  localparam logic [7:0]        C_CODE_BAT  = 8'hAA;

  // Synchroniser flops
  logic clk_r0_q, clk_r1_q, dat_r0_q, dat_r1_q;

  // Receiver / tracker state
  logic [3:0]            bit_cnt_q,    bit_cnt_d;
  logic [C_IDLE_W-1:0]   idle_q,       idle_d;
  logic [9:0]            shift_q,      shift_d;
  logic                  brk_q,        brk_d;
  logic                  ext_q,        ext_d;
  logic [NUM_TRACKS-1:0] held_q,       held_d;
  logic [NUM_TRACKS-1:0] press_q,      press_d;
  logic [NUM_TRACKS-1:0] release_q,    release_d;
  logic                  code_valid_q, code_valid_d;
  logic [7:0]            code_byte_q,  code_byte_d;
  logic                  code_break_q, code_break_d;
  logic                  code_ext_q,   code_ext_d;
  logic                  frame_err_q,  frame_err_d;

  logic                  w_fall;
  logic [7:0]            w_byte;
  logic                  w_frame_ok;
  logic [NUM_TRACKS-1:0] w_match;

  // After ten bits the shift register holds start in [0], data in [8:1]
  // and parity in [9]; the stop bit is still on the synchronised data line.
  assign w_fall     = clk_r1_q & ~clk_r0_q;
  assign w_byte     = shift_q[8:1];
  assign w_frame_ok = ~shift_q[0] & (^shift_q[9:1]) & dat_r1_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TRACKS; gi++) begin : g_match
      assign w_match[gi] = (KEYMAP[8*gi +: 8] == w_byte);
    end
  endgenerate

  // Two-flop synchronisers for the asynchronous PS/2 lines, idle-high
  always_ff @(posedge clk_in) begin
    if (!key_reset) begin
      clk_r0_q <= 1'b1;
      clk_r1_q <= 1'b1;
      dat_r0_q <= 1'b1;
      dat_r1_q <= 1'b1;
    end else begin
      clk_r0_q <= bus.key_clk;
      clk_r1_q <= clk_r0_q;
      dat_r0_q <= bus.key_data;
      dat_r1_q <= dat_r0_q;
    end
  end

  // Next-state: bit collection, timeout abort, frame decode and track update
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    idle_d       = idle_q;
    shift_d      = shift_q;
    brk_d        = brk_q;
    ext_d        = ext_q;
    held_d       = held_q;
    press_d      = '0;
    release_d    = '0;
    code_valid_d = 1'b0;
    code_byte_d  = code_byte_q;
    code_break_d = code_break_q;
    code_ext_d   = code_ext_q;
    frame_err_d  = 1'b0;

    if (w_fall) begin
      idle_d = '0;
      if (bit_cnt_q == C_BIT_STOP) begin
        bit_cnt_d = '0;
        if (!w_frame_ok) begin
          frame_err_d = 1'b1;
          brk_d       = 1'b0;
          ext_d       = 1'b0;
        end else if (w_byte == C_CODE_EXT) begin
          ext_d = 1'b1;
        end else if (w_byte == C_CODE_BRK) begin
          brk_d = 1'b1;
        end else begin
          code_valid_d = 1'b1;
          code_byte_d  = w_byte;
          code_break_d = brk_q;
          code_ext_d   = ext_q;
          brk_d        = 1'b0;
          ext_d        = 1'b0;
          if (!brk_q && (w_byte == C_CODE_BAT)) begin
            // Keyboard self-test / hot-plug: forget every held key silently
            held_d = '0;
          end else begin
            for (int i = 0; i < NUM_TRACKS; i++) begin
              if (w_match[i]) begin
                if (brk_q) begin
                  held_d[i]    = 1'b0;
                  release_d[i] = held_q[i];
                end else begin
                  held_d[i]    = 1'b1;
                  press_d[i]   = ~held_q[i];
                end
              end
            end
          end
        end
      end else begin
        shift_d   = {dat_r1_q, shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (idle_q == C_IDLE_LAST) begin
        bit_cnt_d   = '0;
        idle_d      = '0;
        brk_d       = 1'b0;
        ext_d       = 1'b0;
        frame_err_d = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_in) begin
    if (!key_reset) begin
      bit_cnt_q    <= '0;
      idle_q       <= '0;
      shift_q      <= '0;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      held_q       <= '0;
      press_q      <= '0;
      release_q    <= '0;
      code_valid_q <= 1'b0;
      code_byte_q  <= '0;
      code_break_q <= 1'b0;
      code_ext_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      idle_q       <= idle_d;
      shift_q      <= shift_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      held_q       <= held_d;
      press_q      <= press_d;
      release_q    <= release_d;
      code_valid_q <= code_valid_d;
      code_byte_q  <= code_byte_d;
      code_break_q <= code_break_d;
      code_ext_q   <= code_ext_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.track_held    = held_q;
  assign bus.track_press   = press_q;
  assign bus.track_release = release_q;
  assign bus.code_valid    = code_valid_q;
  assign bus.code_byte     = code_byte_q;
  assign bus.code_break    = code_break_q;
  assign bus.code_ext      = code_ext_q;
  assign bus.frame_err     = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_track_keys.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_ps2_track_keys
// Description : Directed self-checking bench for ps2_track_keys.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_ps2_track_keys;

  localparam int TIMEOUT = 1000;

  logic clk_in    = 1'b0;
  logic key_reset = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse/event accumulators, sampled on the falling clk_in edge
  logic [5:0] acc_press;
  logic [5:0] acc_rel;
  int         n_valid;
  int         n_err;

  ps2_track_keys_if #(.NUM_TRACKS(6)) bus ();

  ps2_track_keys #(
    .NUM_TRACKS     (6),
    .KEYMAP         ({8'h70, 8'h69, 8'h6B, 8'h75, 8'h4A, 8'h0D}),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk_in    (clk_in),
    .key_reset (key_reset),
    .bus       (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_acc();
    acc_press = '0;
    acc_rel   = '0;
    n_valid   = 0;
    n_err     = 0;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_in);
      acc_press = acc_press | bus.track_press;
      acc_rel   = acc_rel | bus.track_release;
      n_valid   = n_valid + int'(bus.code_valid);
      n_err     = n_err + int'(bus.frame_err);
    end
  endtask

  // flaw: 0 none, 1 bad parity, 2 stop=0, 3 start=1
  function automatic logic [10:0] mk(input logic [7:0] b, input int flaw);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    if (flaw == 1) f[9]  = ~f[9];
    if (flaw == 2) f[10] = 1'b0;
    if (flaw == 3) f[0]  = 1'b1;
    return f;
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      bus.key_data = f[i];
      tick(4);
      bus.key_clk = 1'b0;
      tick(10);
      bus.key_clk = 1'b1;
      tick(6);
    end
    bus.key_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input int flaw);
    send_bits(mk(b, flaw), 11);
    tick(8);
  endtask

  initial begin
    int waited;
    bus.key_clk  = 1'b1;
    bus.key_data = 1'b1;
    clr_acc();
    tick(5);
    key_reset = 1'b1;
    tick(3);

    // Reset mid-frame
    send_bits(mk(8'h70, 0), 4);
    key_reset = 1'b0;
    tick(5);
    key_reset = 1'b1;
    tick(1);
    chk("rst_held",  32'(bus.track_held), 32'h0);
    chk("rst_press", 32'(bus.track_press), 32'h0);
    chk("rst_rel",   32'(bus.track_release), 32'h0);
    chk("rst_valid", 32'(bus.code_valid), 32'h0);
    chk("rst_byte",  32'(bus.code_byte), 32'h0);
    chk("rst_brk",   32'(bus.code_break), 32'h0);
    chk("rst_ext",   32'(bus.code_ext), 32'h0);
    chk("rst_err",   32'(bus.frame_err), 32'h0);

    // First make after reset (partial frame must have been dropped)
    clr_acc();
    send(8'h0D, 0);
    chk("mk0d_press", 32'(acc_press), 32'h01);
    chk("mk0d_held",  32'(bus.track_held), 32'h01);
    chk("mk0d_valid", 32'(n_valid), 32'd1);
    chk("mk0d_byte",  32'(bus.code_byte), 32'h0D);
    chk("mk0d_err",   32'(n_err), 32'd0);

    // Release track 0 so the chord starts from empty
    clr_acc();
    send(8'hF0, 0);
    send(8'h0D, 0);
    chk("brk0d_rel",  32'(acc_rel), 32'h01);
    chk("brk0d_held", 32'(bus.track_held), 32'h00);

    // Chord and typematic
    clr_acc();
    send(8'h4A, 0);
    chk("ch4a_press", 32'(acc_press), 32'h02);
    clr_acc();
    send(8'h75, 0);
    chk("ch75_press", 32'(acc_press), 32'h04);
    clr_acc();
    send(8'h4A, 0);
    chk("rep_press", 32'(acc_press), 32'h00);
    chk("rep_valid", 32'(n_valid), 32'd1);
    chk("ch_held",   32'(bus.track_held), 32'h06);

    // Extended break
    clr_acc();
    send(8'hE0, 0);
    send(8'hF0, 0);
    send(8'h4A, 0);
    chk("eb_valid", 32'(n_valid), 32'd1);
    chk("eb_ext",   32'(bus.code_ext), 32'h1);
    chk("eb_brk",   32'(bus.code_break), 32'h1);
    chk("eb_rel",   32'(acc_rel), 32'h02);
    chk("eb_held",  32'(bus.track_held), 32'h04);

    // Break of an already released key
    clr_acc();
    send(8'hF0, 0);
    send(8'h4A, 0);
    chk("b2_rel",   32'(acc_rel), 32'h00);
    chk("b2_valid", 32'(n_valid), 32'd1);
    chk("b2_ext",   32'(bus.code_ext), 32'h0);
    chk("b2_brk",   32'(bus.code_break), 32'h1);

    // Frame errors: parity, stop, start
    for (int fl = 1; fl <= 3; fl++) begin
      clr_acc();
      send(8'h70, fl);
      chk($sformatf("ferr%0d_err", fl),   32'(n_err), 32'd1);
      chk($sformatf("ferr%0d_valid", fl), 32'(n_valid), 32'd0);
      chk($sformatf("ferr%0d_held", fl),  32'(bus.track_held), 32'h04);
      chk($sformatf("ferr%0d_press", fl), 32'(acc_press), 32'h00);
    end

    // Timeout clears a pending break prefix
    clr_acc();
    send(8'hF0, 0);
    send_bits(mk(8'h33, 0), 4);
    waited = 0;
    while (n_err == 0 && waited < TIMEOUT + 50) begin
      tick(1);
      waited++;
    end
    chk("to_err",   32'(n_err), 32'd1);
    chk("to_late",  32'(waited >= TIMEOUT - 40), 32'd1);
    chk("to_early", 32'(waited <= TIMEOUT + 10), 32'd1);
    tick(5);
    clr_acc();
    send(8'h70, 0);
    chk("to_press", 32'(acc_press), 32'h20);
    chk("to_brk",   32'(bus.code_break), 32'h0);
    chk("to_held",  32'(bus.track_held), 32'h24);

    // BAT clears everything without release pulses
    send(8'h0D, 0);
    send(8'h4A, 0);
    send(8'h6B, 0);
    send(8'h69, 0);
    chk("all_held", 32'(bus.track_held), 32'h3F);
    clr_acc();
    send(8'hAA, 0);
    chk("bat_held",  32'(bus.track_held), 32'h00);
    chk("bat_rel",   32'(acc_rel), 32'h00);
    chk("bat_valid", 32'(n_valid), 32'd1);
    chk("bat_byte",  32'(bus.code_byte), 32'hAA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
